// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle for the register file with load-use scoreboard.
// The master side is decode/writeback; the slave side is the register file.
interface regfile_sb_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned NREAD = 2
);
   localparam int unsigned ADDR_W = $clog2(NREGS);

   logic                      en;
   logic                      wr_load;
   logic [ADDR_W-1:0]         wr_dest;
   logic [WIDTH-1:0]          wr_data;
   logic [NREAD*ADDR_W-1:0]   rd_addr;
   logic [NREAD-1:0]          rd_use;
   logic [NREAD*WIDTH-1:0]    rd_data;
   logic                      issue_valid;
   logic [ADDR_W-1:0]         issue_rd;
   logic                      issue_pending;
   logic                      flush;
   logic [NREAD-1:0]          busy;
   logic                      stall;

   modport master (
      output en, wr_load, wr_dest, wr_data, rd_addr, rd_use,
             issue_valid, issue_rd, issue_pending, flush,
      input  rd_data, busy, stall
   );

   modport slave (
      input  en, wr_load, wr_dest, wr_data, rd_addr, rd_use,
             issue_valid, issue_rd, issue_pending, flush,
      output rd_data, busy, stall
   );
endinterface

// File: rtl/regfile_sb.sv
// Register file with zero-latency bypassed reads and a per-register pending
// scoreboard that flags load-use hazards to decode.
module regfile_sb #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned NREAD = 2
) (
   input  logic         clk,
   input  logic         rst,
   regfile_sb_if.slave  bus
);
   localparam int unsigned ADDR_W = $clog2(NREGS);

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [NREGS-1:0] pending_q;
   logic [NREGS-1:0] pending_d;

   logic             wr_fire_c;
   logic             wr_commit_c;
   logic [NREAD-1:0] busy_c;
   logic             stall_c;

   assign wr_fire_c   = bus.en && bus.wr_load;
   assign wr_commit_c = wr_fire_c && (bus.wr_dest != '0);

   // Per-port read mux with writeback bypass and hazard detection.
   for (genvar g = 0; g < int'(NREAD); g++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = bus.rd_addr[g*ADDR_W +: ADDR_W];
      assign bus.rd_data[g*WIDTH +: WIDTH] =
         (wr_commit_c && (bus.wr_dest == addr)) ? bus.wr_data : regs_q[addr];
      assign busy_c[g] = bus.rd_use[g] && (addr != '0) && pending_q[addr] &&
                         !(wr_fire_c && (bus.wr_dest == addr));
   end

   assign stall_c  = |busy_c;
   assign bus.busy  = busy_c;
   assign bus.stall = stall_c;

   // Ordering gives clear < set < flush priority on the pending bits.
   always_comb begin
      regs_d    = regs_q;
      pending_d = pending_q;
      if (wr_commit_c) begin
         regs_d[bus.wr_dest] = bus.wr_data;
      end
      if (wr_fire_c) begin
         pending_d[bus.wr_dest] = 1'b0;
      end
      if (bus.en && bus.issue_valid && bus.issue_pending && !stall_c &&
          (bus.issue_rd != '0)) begin
         pending_d[bus.issue_rd] = 1'b1;
      end
      if (bus.flush) begin
         pending_d = '0;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         pending_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         pending_q <= pending_d;
      end
   end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reads, bypass, scoreboard set/clear/flush,
// enable gating and asynchronous reset, all against hand-computed values.
module tb_regfile_sb;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned NREAD = 2;
   localparam int unsigned AW    = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   regfile_sb_if #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD)) bus ();

   regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.en            = 1'b1;
      bus.wr_load       = 1'b0;
      bus.wr_dest       = '0;
      bus.wr_data       = '0;
      bus.rd_addr       = '0;
      bus.rd_use        = '0;
      bus.issue_valid   = 1'b0;
      bus.issue_rd      = '0;
      bus.issue_pending = 1'b0;
      bus.flush         = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int p, input logic [AW-1:0] a, input logic u);
      bus.rd_addr[p*AW +: AW] = a;
      bus.rd_use[p]           = u;
   endtask

   task automatic do_write(input logic [AW-1:0] d, input logic [WIDTH-1:0] v);
      bus.wr_load = 1'b1;
      bus.wr_dest = d;
      bus.wr_data = v;
   endtask

   task automatic do_issue(input logic [AW-1:0] d);
      bus.issue_valid   = 1'b1;
      bus.issue_rd      = d;
      bus.issue_pending = 1'b1;
   endtask

   function automatic logic [WIDTH-1:0] rdat(input int p);
      return bus.rd_data[p*WIDTH +: WIDTH];
   endfunction

   initial begin
      idle();
      #2 rst = 1'b1;
      #1;
      set_rd(0, 5'd5, 1'b1);
      check_eq("reset_rd0", 64'(rdat(0)), 64'h0);
      check_eq("reset_busy", 64'(bus.busy), 64'h0);
      check_eq("reset_stall", 64'(bus.stall), 64'h0);
      tick();
      rst = 1'b0;
      idle();

      // Write then read on both ports
      do_write(5'd5, 32'hDEADBEEF);
      tick();
      idle();
      set_rd(0, 5'd5, 1'b0);
      set_rd(1, 5'd5, 1'b0);
      #1;
      check_eq("wr_rd0", 64'(rdat(0)), 64'hDEADBEEF);
      check_eq("wr_rd1_same", 64'(rdat(1)), 64'hDEADBEEF);

      // Same-cycle bypass and x0 discard
      do_write(5'd7, 32'h1234);
      set_rd(1, 5'd7, 1'b0);
      #1;
      check_eq("bypass_rd1", 64'(rdat(1)), 64'h1234);
      tick();
      idle();
      set_rd(1, 5'd7, 1'b0);
      #1;
      check_eq("after_bypass", 64'(rdat(1)), 64'h1234);
      do_write(5'd0, 32'hFFFF);
      set_rd(0, 5'd0, 1'b1);
      #1;
      check_eq("x0_bypass", 64'(rdat(0)), 64'h0);
      tick();
      idle();
      set_rd(0, 5'd0, 1'b1);
      #1;
      check_eq("x0_read", 64'(rdat(0)), 64'h0);
      check_eq("x0_busy", 64'(bus.busy), 64'h0);

      // Load-use hazard resolved by writeback
      do_issue(5'd3);
      tick();
      idle();
      set_rd(0, 5'd3, 1'b1);
      set_rd(1, 5'd3, 1'b0);
      #1;
      check_eq("lu_busy", 64'(bus.busy), 64'h1);
      check_eq("lu_stall", 64'(bus.stall), 64'h1);
      set_rd(1, 5'd3, 1'b1);
      #1;
      check_eq("lu_busy_both", 64'(bus.busy), 64'h3);
      do_write(5'd3, 32'hA5A5A5A5);
      #1;
      check_eq("lu_wb_busy", 64'(bus.busy), 64'h0);
      check_eq("lu_wb_stall", 64'(bus.stall), 64'h0);
      check_eq("lu_wb_data", 64'(rdat(0)), 64'hA5A5A5A5);
      tick();
      idle();
      set_rd(0, 5'd3, 1'b1);
      #1;
      check_eq("lu_cleared", 64'(bus.busy), 64'h0);

      // Set wins over clear on the same register
      do_issue(5'd4);
      tick();
      idle();
      do_write(5'd4, 32'h44);
      do_issue(5'd4);
      tick();
      idle();
      set_rd(0, 5'd4, 1'b1);
      #1;
      check_eq("conf_busy", 64'(bus.busy), 64'h1);
      check_eq("conf_data", 64'(rdat(0)), 64'h44);
      // A stalled issue must not mark its destination
      do_issue(5'd8);
      #1;
      check_eq("stall_on", 64'(bus.stall), 64'h1);
      tick();
      idle();
      set_rd(1, 5'd8, 1'b1);
      #1;
      check_eq("stall_no_set", 64'(bus.busy), 64'h0);
      // Flush clears everything and beats a simultaneous set
      bus.flush = 1'b1;
      do_issue(5'd6);
      do_write(5'd12, 32'hC0C0);
      tick();
      idle();
      set_rd(0, 5'd4, 1'b1);
      set_rd(1, 5'd6, 1'b1);
      #1;
      check_eq("flush_busy", 64'(bus.busy), 64'h0);
      check_eq("flush_stall", 64'(bus.stall), 64'h0);
      set_rd(0, 5'd12, 1'b0);
      #1;
      check_eq("flush_wr", 64'(rdat(0)), 64'hC0C0);

      // Enable low holds all state
      bus.en = 1'b0;
      do_write(5'd9, 32'h999);
      do_issue(5'd10);
      set_rd(0, 5'd9, 1'b0);
      #1;
      check_eq("en0_nobypass", 64'(rdat(0)), 64'h0);
      tick();
      idle();
      set_rd(0, 5'd9, 1'b0);
      set_rd(1, 5'd10, 1'b1);
      #1;
      check_eq("en0_x9", 64'(rdat(0)), 64'h0);
      check_eq("en0_noset", 64'(bus.busy), 64'h0);
      do_issue(5'd11);
      tick();
      idle();
      bus.en = 1'b0;
      do_write(5'd11, 32'h11);
      set_rd(0, 5'd11, 1'b1);
      #1;
      check_eq("en0_busy_held", 64'(bus.busy), 64'h1);
      bus.wr_load = 1'b0;
      tick();
      check_eq("en0_still_pend", 64'(bus.busy), 64'h1);
      bus.flush = 1'b1;
      tick();
      idle();
      set_rd(0, 5'd11, 1'b1);
      #1;
      check_eq("en0_flush", 64'(bus.busy), 64'h0);

      // Asynchronous reset between edges
      do_write(5'd2, 32'h55);
      do_issue(5'd2);
      tick();
      idle();
      set_rd(0, 5'd2, 1'b1);
      #1;
      check_eq("ar_pre_busy", 64'(bus.busy), 64'h1);
      check_eq("ar_pre_data", 64'(rdat(0)), 64'h55);
      #1 rst = 1'b1;
      #1;
      check_eq("ar_data", 64'(rdat(0)), 64'h0);
      check_eq("ar_stall", 64'(bus.stall), 64'h0);
      #1 rst = 1'b0;
      #1;
      check_eq("ar_post_stall", 64'(bus.stall), 64'h0);
      tick();
      check_eq("ar_post_edge", 64'(bus.busy), 64'h0);
      check_eq("ar_post_x5", 64'(rdat(0)), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
